// File: rtl/perf_monitor_if.sv
// perf_monitor_if: request/valid read-back bundle for perf_monitor.
// The master issues rd_req/rd_sel; the slave returns a held snapshot.
interface perf_monitor_if #(
    parameter int WIDTH = 16
);
    logic             rd_req;
    logic [1:0]       rd_sel;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;

    modport master (
        output rd_req,
        output rd_sel,
        input  rd_data,
        input  rd_valid
    );

    modport slave (
        input  rd_req,
        input  rd_sel,
        output rd_data,
        output rd_valid
    );
endinterface

// File: rtl/perf_monitor.sv
// perf_monitor: event counters and halt detector fed by the control FSM strobes.
// Define PERF_SATURATE_EN to make the counters saturate instead of wrapping.
module perf_monitor #(
    parameter int WIDTH       = 16,
    parameter int HALT_WINDOW = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          IncCount,
    input  logic          IRload,
    input  logic          PCwrite,
    input  logic          MemRead,
    input  logic          MemWrite,
    input  logic          clear,
    perf_monitor_if.slave rd,
    output logic          halted,
    output logic [3:0]    ovf
);
    localparam int GW = (HALT_WINDOW > 1) ? $clog2(HALT_WINDOW) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(HALT_WINDOW - 1);
    localparam logic [WIDTH-1:0] ONES = '1;

    typedef enum logic [1:0] {IDLE, RUN, HALT} run_e;
    typedef enum logic {R_IDLE, R_HOLD} rd_e;

    run_e             state;
    run_e             state_nxt;
    rd_e              rstate;
    rd_e              rstate_nxt;
    logic [GW-1:0]    gap;
    logic [3:0]       inc;
    logic [WIDTH-1:0] cnt [4];
    logic [WIDTH-1:0] data_q;

    // Run FSM: state register
    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Run FSM: next state
    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: if (IncCount) state_nxt = RUN;
                RUN:  if (!IncCount && gap == GAP_LAST) state_nxt = HALT;
                HALT: if (IncCount) state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Run FSM: outputs; in HALT only the waking IncCount is counted
    always_comb begin
        halted = (state == HALT);
        inc[0] = IncCount;
        inc[1] = IRload;
        inc[2] = (MemRead | MemWrite) & ~IRload;
        inc[3] = PCwrite & ~IRload;
        if (state == HALT) inc[3:1] = 3'b000;
    end

    always_ff @(posedge clock) begin
        if (!reset || clear)
            gap <= '0;
        else if (state == RUN && !IncCount && gap != GAP_LAST)
            gap <= gap + 1'b1;
        else
            gap <= '0;
    end

    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
            ovf <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (inc[i]) begin
                    if (cnt[i] == ONES) ovf[i] <= 1'b1;
`ifdef PERF_SATURATE_EN
                    if (cnt[i] != ONES) cnt[i] <= cnt[i] + 1'b1;
`else
                    cnt[i] <= cnt[i] + 1'b1;
`endif
                end
            end
        end
    end

    // Read FSM: state register
    always_ff @(posedge clock) begin
        if (!reset) rstate <= R_IDLE;
        else        rstate <= rstate_nxt;
    end

    // Read FSM: next state
    always_comb begin
        rstate_nxt = rstate;
        unique case (rstate)
            R_IDLE: if (rd.rd_req)  rstate_nxt = R_HOLD;
            R_HOLD: if (!rd.rd_req) rstate_nxt = R_IDLE;
        endcase
    end

    // Read FSM: outputs
    always_comb begin
        rd.rd_valid = (rstate == R_HOLD);
        rd.rd_data  = data_q;
    end

    // Snapshot takes the pre-edge count, so a same-edge clear is not seen
    always_ff @(posedge clock) begin
        if (!reset)
            data_q <= '0;
        else if (rstate == R_IDLE && rd.rd_req)
            data_q <= cnt[rd.rd_sel];
    end
endmodule

// File: tb/tb_perf_monitor.sv
// tb_perf_monitor: directed and random stimulus against an event-level model.
// Outputs are compared every cycle on the falling edge.
module tb_perf_monitor;
    localparam int W    = 4;
    localparam int HW   = 4;
    localparam int MAXV = (1 << W) - 1;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       IncCount = 1'b0;
    logic       IRload = 1'b0;
    logic       PCwrite = 1'b0;
    logic       MemRead = 1'b0;
    logic       MemWrite = 1'b0;
    logic       clear = 1'b0;
    logic       halted;
    logic [3:0] ovf;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    perf_monitor_if #(.WIDTH(W)) bus ();

    perf_monitor #(.WIDTH(W), .HALT_WINDOW(HW)) dut (
        .clock    (clock),
        .reset    (reset),
        .IncCount (IncCount),
        .IRload   (IRload),
        .PCwrite  (PCwrite),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .clear    (clear),
        .rd       (bus.slave),
        .halted   (halted),
        .ovf      (ovf)
    );

    always #5 clock = ~clock;

    // Model: event totals per counter, mode 0 idle / 1 run / 2 halt
    int       m_cnt [4];
    logic [3:0] m_ovf = 4'b0000;
    int       m_mode = 0;
    int       m_low = 0;
    bit       m_hold = 1'b0;
    int       m_data = 0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clock) begin
        bit ev [4];
        if (!reset) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_ovf = 4'b0000;
            m_mode = 0;
            m_low = 0;
            m_hold = 1'b0;
            m_data = 0;
        end else begin
            if (!m_hold && bus.rd_req) begin
                m_data = m_cnt[bus.rd_sel];
                m_hold = 1'b1;
            end else if (m_hold && !bus.rd_req) begin
                m_hold = 1'b0;
            end
            if (clear) begin
                foreach (m_cnt[i]) m_cnt[i] = 0;
                m_ovf = 4'b0000;
                m_mode = 0;
                m_low = 0;
            end else begin
                ev[0] = IncCount;
                ev[1] = IRload;
                ev[2] = (MemRead || MemWrite) && !IRload;
                ev[3] = PCwrite && !IRload;
                if (m_mode == 2) begin
                    ev[1] = 1'b0;
                    ev[2] = 1'b0;
                    ev[3] = 1'b0;
                end
                for (int i = 0; i < 4; i++) begin
                    if (ev[i]) begin
                        if (m_cnt[i] == MAXV) m_ovf[i] = 1'b1;
`ifdef PERF_SATURATE_EN
                        if (m_cnt[i] < MAXV) m_cnt[i] = m_cnt[i] + 1;
`else
                        m_cnt[i] = (m_cnt[i] + 1) % (MAXV + 1);
`endif
                    end
                end
                if (m_mode == 0) begin
                    if (IncCount) m_mode = 1;
                end else if (m_mode == 1) begin
                    if (IncCount) m_low = 0;
                    else begin
                        m_low++;
                        if (m_low == HW) begin
                            m_mode = 2;
                            m_low = 0;
                        end
                    end
                end else begin
                    if (IncCount) begin
                        m_mode = 1;
                        m_low = 0;
                    end
                end
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("rd_valid", int'(bus.rd_valid), int'(m_hold));
            chk("rd_data", int'(bus.rd_data), m_data);
            chk("halted", int'(halted), int'(m_mode == 2));
            chk("ovf", int'(ovf), int'(m_ovf));
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic do_read(input int sel, output int val);
        int n;
        bus.rd_req = 1'b1;
        bus.rd_sel = 2'(sel);
        tick();
        n = 0;
        while (!bus.rd_valid && n < 8) begin
            tick();
            n++;
        end
        chk("rd_valid_rise", int'(bus.rd_valid), 1);
        val = int'(bus.rd_data);
        bus.rd_req = 1'b0;
        tick();
        n = 0;
        while (bus.rd_valid && n < 8) begin
            tick();
            n++;
        end
        chk("rd_valid_fall", int'(bus.rd_valid), 0);
    endtask

    task automatic set_ev(bit inc, bit ir, bit mr, bit pc);
        IncCount = inc;
        IRload = ir;
        MemRead = mr;
        PCwrite = pc;
        MemWrite = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int v;
        int c0;
        int c1;
        int burst;
        bus.rd_req = 1'b0;
        bus.rd_sel = 2'd0;
        tick();
        tick();
        chk_en = 1'b1;
        chk("reset_valid", int'(bus.rd_valid), 0);
        chk("reset_data", int'(bus.rd_data), 0);
        chk("reset_halted", int'(halted), 0);
        chk("reset_ovf", int'(ovf), 0);
        reset = 1'b1;

        // Basic counting
        for (int c = 0; c < 10; c++) begin
            set_ev(1'b1, c == 0 || c == 4 || c == 8, c == 0 || c == 6,
                   c == 0 || c == 7);
            tick();
        end
        set_ev(1'b0, 1'b0, 1'b0, 1'b0);
        do_read(0, v); chk("basic_cyc", v, 10);
        do_read(1, v); chk("basic_ins", v, 3);
        do_read(2, v); chk("basic_mem", v, 1);
        do_read(3, v); chk("basic_br", v, 1);

        // Halt detection
        IncCount = 1'b1; tick();
        IncCount = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("no_halt_3low", int'(halted), 0);
        end
        IncCount = 1'b1; tick();
        chk("no_halt_after_inc", int'(halted), 0);
        IncCount = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("no_halt_yet", int'(halted), 0);
        end
        tick();
        chk("halt_rise", int'(halted), 1);
        do_read(0, c0);
        chk("halt_cyc_before", c0, 12);
        IncCount = 1'b1; tick();
        chk("halt_fall", int'(halted), 0);
        IncCount = 1'b0;
        do_read(0, c1);
        chk("halt_ret_count", c1, 13);

        // Wrap / saturate
        clear = 1'b1; tick(); clear = 1'b0;
        IncCount = 1'b1;
        for (int k = 0; k < 17; k++) tick();
        IncCount = 1'b0;
        do_read(0, v);
`ifdef PERF_SATURATE_EN
        chk("sat_cyc", v, 15);
`else
        chk("wrap_cyc", v, 1);
`endif
        chk("wrap_ovf", int'(ovf), 1);

        // Clear priority
        clear = 1'b1; tick(); clear = 1'b0;
        set_ev(1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) tick();
        set_ev(1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) tick();
        chk("pre_clear_halted", int'(halted), 1);
        chk("model_ins5", m_cnt[1], 5);
        clear = 1'b1; IRload = 1'b1; tick();
        clear = 1'b0; IRload = 1'b0;
        chk("clear_halted", int'(halted), 0);
        chk("clear_ovf", int'(ovf), 0);
        for (int k = 0; k < 6; k++) tick();
        chk("idle_never_halts", int'(halted), 0);
        do_read(1, v); chk("clear_ins", v, 0);

        // Read handshake
        clear = 1'b1; tick(); clear = 1'b0;
        IncCount = 1'b1;
        bus.rd_req = 1'b1; bus.rd_sel = 2'd0;
        tick();
        chk("snap_valid", int'(bus.rd_valid), 1);
        chk("snap0", int'(bus.rd_data), 0);
        for (int k = 1; k < 5; k++) begin
            if (k == 2) bus.rd_sel = 2'd1;
            tick();
            chk("hold_const", int'(bus.rd_data), 0);
        end
        bus.rd_req = 1'b0; tick();
        chk("drop_valid", int'(bus.rd_valid), 0);
        bus.rd_req = 1'b1; bus.rd_sel = 2'd0; tick();
        chk("resnap", int'(bus.rd_data), 6);
        bus.rd_req = 1'b0; IncCount = 1'b0; tick();

        // Reset mid-operation
        set_ev(1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) tick();
        set_ev(1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) tick();
        bus.rd_req = 1'b1; bus.rd_sel = 2'd1; tick();
        chk("mid_valid", int'(bus.rd_valid), 1);
        chk("mid_halted", int'(halted), 1);
        reset = 1'b0; tick();
        chk("rst_valid", int'(bus.rd_valid), 0);
        chk("rst_halted", int'(halted), 0);
        chk("rst_data", int'(bus.rd_data), 0);
        chk("rst_ovf", int'(ovf), 0);
        reset = 1'b1; IncCount = 1'b1; bus.rd_sel = 2'd0; tick();
        chk("post_rst_snap_valid", int'(bus.rd_valid), 1);
        chk("post_rst_snap", int'(bus.rd_data), 0);
        bus.rd_req = 1'b0; IncCount = 1'b0; tick();
        do_read(0, v); chk("post_rst_cyc", v, 1);

        // Random traffic
        burst = 5;
        for (int c = 0; c < 1500; c++) begin
            if (c % 20 == 0) burst = $urandom_range(0, 10);
            IncCount = ($urandom_range(0, 9) < burst);
            IRload = ($urandom_range(0, 3) == 0);
            MemRead = $urandom_range(0, 1) == 1;
            MemWrite = $urandom_range(0, 3) == 0;
            PCwrite = $urandom_range(0, 2) == 0;
            clear = ($urandom_range(0, 59) == 0);
            reset = ($urandom_range(0, 249) != 0);
            bus.rd_sel = 2'($urandom_range(0, 3));
            if (bus.rd_req && bus.rd_valid && $urandom_range(0, 1) == 1)
                bus.rd_req = 1'b0;
            else if (!bus.rd_req && !bus.rd_valid && $urandom_range(0, 2) == 0)
                bus.rd_req = 1'b1;
            tick();
        end
        reset = 1'b1;
        clear = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/perf_monitor.md
# perf_monitor

Event-counting monitor that sits directly downstream of the multi-cycle control FSM and consumes its control outputs (IncCount, IRload, PCwrite, MemRead, MemWrite). It keeps four counters (active cycles, fetched instructions, data memory accesses, taken PC writes) and detects processor halt from a sustained IncCount drop. Results are read out through a 4-phase request/valid handshake that returns a stable snapshot.

## Interface
- WIDTH, 16: width of each event counter and of rd_data.
- HALT_WINDOW, 4: number of consecutive IncCount=0 cycles in RUN that declare a halt (≥1).

- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low; sampled on the clock edge.
- IncCount  in  1  FSM cycle-count enable.
- IRload  in  1  FSM instruction-fetch strobe.
- PCwrite  in  1  FSM PC write enable.
- MemRead  in  1  FSM memory read enable.
- MemWrite  in  1  FSM memory write enable.
- clear  in  1  synchronous counter clear, 1-cycle pulse or level.
- rd_req  in  1  read request, held until rd_valid observed.
- rd_sel  in  2  counter select: 0 cycles, 1 instructions, 2 data accesses, 3 taken PC writes.
- rd_data  out  WIDTH  snapshot of the selected counter.
- rd_valid  out  1  rd_data holds a valid snapshot.
- halted  out  1  processor is halted (state HALT).
- ovf  out  4  sticky per-counter overflow, bit index = rd_sel code.

## Operation
- Events are sampled every edge:
  - cyc_cnt += IncCount.
  - ins_cnt += IRload.
  - mem_cnt += (MemRead|MemWrite)&~IRload, which excludes fetches.
  - br_cnt += PCwrite&~IRload, which excludes the fetch PC increment.
- Run FSM states:
  - IDLE: out of reset or clear. Goes to RUN on IncCount=1.
  - RUN: gap counter resets to 0 on IncCount=1 and increments otherwise. On an edge with IncCount=0 and gap==HALT_WINDOW-1, goes to HALT.
  - HALT: goes to RUN on IncCount=1. The gap counter is 0 on entering RUN.
- Counters increment in IDLE and RUN. In HALT only the IncCount-triggered return is counted: cyc_cnt increments on that edge.
- clear: all counters, ovf and gap go to 0, and the run FSM goes to IDLE. clear has priority over same-cycle increments. It does not touch the read FSM, rd_data or rd_valid.
- Read FSM states:
  - R_IDLE: on rd_req=1, captures counter[rd_sel] (register value before this edge's update) into rd_data, sets rd_valid=1, and moves to R_HOLD.
  - R_HOLD: rd_data is frozen and rd_req/rd_sel are ignored. On rd_req=0, clears rd_valid and returns to R_IDLE. rd_data keeps its last value.
- Arithmetic: unsigned, modulo 2^WIDTH. ovf[i] is set on the edge where counter i increments from all-ones. It stays set until clear or reset.
- Simultaneous clear and rd_req in R_IDLE: the snapshot takes the pre-clear value.

## Timing
- Reset (reset=0 at an edge) sets: all counters 0, gap 0, run FSM IDLE, read FSM R_IDLE, rd_data 0, rd_valid 0, halted 0, ovf 0.
- Reset overrides clear, rd_req and events, including mid-read and mid-halt.
- Counter update latency is 1 edge: an event in cycle n is visible at readout from cycle n+1.
- halted is registered (state==HALT). It rises in the cycle after the HALT_WINDOW-th consecutive low IncCount cycle in RUN.
- halted falls in the cycle after an IncCount=1 cycle.
- IDLE never asserts halted, even if IncCount stays low indefinitely.
- Read latency: rd_valid rises 1 cycle after rd_req is first sampled high. It falls 1 cycle after rd_req is sampled low.
- Minimum period between back-to-back reads is 2 cycles of rd_req=0/1 toggling.

## Configuration
- PERF_SATURATE_EN defined: counters saturate at all-ones and never wrap. ovf[i] is set on the first increment attempted while counter i is all-ones.
- PERF_SATURATE_EN undefined: counters wrap to 0 and set ovf[i] as described under Operation.
- Both variants share the same ports and reset values.

## Test plan
- Basic counting:
  - Stimulus: IncCount=1 for 10 cycles; IRload on cycles 0, 4, 8; MemRead on cycles 0 and 6; PCwrite on cycles 0 and 7; then read sel 0..3.
  - Required: 10, 3, 1, 1.
- Halt detection (HALT_WINDOW=4):
  - From RUN, IncCount=0 for 3 cycles then 1: halted stays 0.
  - IncCount=0 for 4 cycles: halted=1 from the 5th cycle.
  - IncCount=1 once: halted=0 one cycle later, and cyc_cnt has incremented by 1.
- Wrap (WIDTH=4, macro undefined):
  - 17 IncCount cycles: cyc_cnt reads 1, ovf=4'b0001.
  - Same stimulus with PERF_SATURATE_EN: reads 15, ovf=4'b0001.
- Clear priority:
  - clear and IRload in the same cycle with ins_cnt=5: ins_cnt reads 0, ovf 0, run FSM IDLE, halted 0.
- Read handshake:
  - rd_req high for 5 cycles while IncCount=1: rd_data is constant and equals cyc_cnt at the request edge.
  - Changing rd_sel mid-hold has no effect.
  - Drop rd_req, re-request: rd_data reflects the 5+ extra counts.
- Reset mid-operation:
  - reset=0 for one edge while rd_valid=1, halted=1, counters nonzero: next cycle all outputs 0.
  - A sampled rd_req=1 after reset deasserts gives a new snapshot of 0 (plus events since).
